vga_pixel_sink: RTL and testbench
=================================

VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

Interface
REQ-001 Parameter PIX_DIV, default 4: number of clk cycles per pixel step; legal range 2..16.
REQ-002 Port clk  input  1: single clock; all logic SHALL be rising-edge.
REQ-003 Port reset  input  1: synchronous, active-high reset.
REQ-004 Port x_in  input  8: pixel column of a write request.
REQ-005 Port y_in  input  7: pixel row of a write request.
REQ-006 Port color_in  input  3: RGB value of a write request.
REQ-007 Port writeEn  input  1: write request strobe, one pixel per high cycle.
REQ-008 Port rgb_out  output  3: scanned-out pixel colour, 0 outside the active area.
REQ-009 Port hsync  output  1: horizontal sync, active low.
REQ-010 Port vsync  output  1: vertical sync, active low.
REQ-011 Port video_on  output  1: high while the scan position is inside 160x120.
REQ-012 Port frame_start  output  1: one-clk pulse at scan position (0,0).
REQ-013 Port clearing  output  1: high while the clear sweep runs.
REQ-014 Port drop_count  output  8: saturating count of rejected write requests.

Function
REQ-015 Framebuffer SHALL hold 19200 entries of 3 bits, addressed as y*160+x (15 bits), computed as (y<<7)+(y<<5)+x.
REQ-016 A request with writeEn=1, x_in<160, y_in<120 and clearing=0 SHALL write color_in at the next clk edge.
REQ-017 A request with writeEn=1 and x_in>=160, y_in>=120 or clearing=1 SHALL be dropped and SHALL increment drop_count; the increment stops at 255.
REQ-018 A pixel enable SHALL pulse for one clk every PIX_DIV clks, driven by a divider counter.
REQ-019 On each pixel enable, h SHALL advance 0..199 and wrap to 0; on an h wrap, v SHALL advance 0..130 and wrap to 0.
REQ-020 hsync SHALL be low for h in 168..183; vsync SHALL be low for v in 122..123; both outputs SHALL be registered.
REQ-021 video_on, hsync and vsync SHALL be delayed 2 clks after the counter update, so they align with rgb_out.
REQ-022 rgb_out SHALL be the framebuffer entry at (h,v), produced by a registered read address followed by a registered data stage: 2 clks after the counter update.
REQ-023 rgb_out SHALL be 0 whenever the aligned video_on is 0.
REQ-024 If a read and a write hit the same address in the same clk, the read SHALL return the old data.
REQ-025 frame_start SHALL pulse for one clk when the aligned (h,v) becomes (0,0).
REQ-026 The write path and the scan path SHALL be independent; writes are never stalled and there is no backpressure.

Reset
REQ-027 While reset=1: h, v, the divider and drop_count SHALL be 0; rgb_out=0; hsync=1; vsync=1; video_on=0; frame_start=0.
REQ-028 A reset asserted mid-frame or mid-clear SHALL abort the operation; scanning SHALL restart from (0,0) on the first clk after reset deasserts.
REQ-029 A write request during reset SHALL be ignored and SHALL NOT be counted.

Configuration
REQ-030 Macro VGA_PIXEL_SINK_CLEAR_EN defined: after reset deasserts, a two-state FSM (S_CLEAR, S_RUN) SHALL write 0 to addresses 0..19199, one per clk.
REQ-031 With the macro defined, clearing SHALL be high for exactly 19200 clks, then the FSM SHALL go to S_RUN; scanning runs during the clear.
REQ-032 Macro undefined: no FSM; clearing SHALL be tied 0; framebuffer contents after reset are unspecified.

Verification
REQ-033 Write (x=5, y=3, color=3'b101), then scan -> rgb_out=101 at h=5, v=3, and 0 at h=4 and h=6.
REQ-034 Write (x=160, y=0) and (x=0, y=120) -> no framebuffer change; drop_count=2. Then 300 drops -> drop_count holds at 255.
REQ-035 PIX_DIV=4, run 1 frame -> 200*131*4=104800 clks between frame_start pulses; hsync low for 16 pixel steps per line; vsync low for 2 lines.
REQ-036 Write to (10,10) in the same clk the scan reads (10,10) -> old value seen in this frame, new value in the next frame.
REQ-037 With VGA_PIXEL_SINK_CLEAR_EN: preload 7 everywhere, then reset -> clearing high for 19200 clks; writes during the clear are dropped; the next frame shows all 0.
REQ-038 Assert reset at h=90, v=60 -> outputs reach reset values; frame_start pulses 2 clks after the first post-reset counter update.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink
//   160x120 framebuffer (3-bit colour) with an independent write port and a
//   200x131-position raster scanner that streams the stored pixels out.
//
//   Parameters
//     PIX_DIV      clk cycles per pixel step (2..16)
//   Ports
//     clk          rising-edge clock
//     reset        synchronous, active-high reset
//     x_in, y_in   write pixel coordinates
//     color_in     write colour
//     writeEn      write strobe, one pixel per high cycle
//     rgb_out      scanned pixel, 0 outside the visible area
//     hsync/vsync  active-low sync, aligned with rgb_out
//     video_on     scan position inside 160x120, aligned with rgb_out
//     frame_start  one-clk pulse when the aligned position becomes (0,0)
//     clearing     high while the post-reset clear sweep runs
//     drop_count   saturating count of rejected write requests
//
//   Build option
//     VGA_PIXEL_SINK_CLEAR_EN  defined: every reset is followed by a sweep
//     that writes 0 to all 19200 entries; writes are rejected meanwhile.
//     Undefined: no sweep, clearing is tied low.
module vga_pixel_sink #(
    parameter int PIX_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] color_in,
    input  logic       writeEn,
    output logic [2:0] rgb_out,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic       clearing,
    output logic [7:0] drop_count
);

    localparam int NPIX  = 19200;
    localparam int DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);

    function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] yy;
        yy = {8'd0, y};
        // y*160 + x without a multiplier
        return (yy << 7) + (yy << 5) + {7'd0, x};
    endfunction

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       h_q, h_d;
    logic [7:0]       v_q, v_d;
    logic             pix_en;

    always_comb begin
        pix_en = (div_q == DIV_MAX);
        div_d  = pix_en ? '0 : div_q + 1'b1;
        h_d    = h_q;
        v_d    = v_q;
        if (pix_en) begin
            if (h_q == 8'd199) begin
                h_d = 8'd0;
                v_d = (v_q == 8'd130) ? 8'd0 : v_q + 8'd1;
            end else begin
                h_d = h_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: read address and decoded timing for the current position
    // ------------------------------------------------------------------
    logic [14:0] rd_addr_q, rd_addr_d;
    logic        vid1_q, vid1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        zero1_q, zero1_d;

    always_comb begin
        vid1_d    = (h_q < 8'd160) && (v_q < 8'd120);
        // Outside the visible area the address is parked at 0 so it never
        // runs past the end of the array.
        rd_addr_d = vid1_d ? pix_addr(h_q, v_q[6:0]) : 15'd0;
        hs1_d     = !((h_q >= 8'd168) && (h_q <= 8'd183));
        vs1_d     = !((v_q >= 8'd122) && (v_q <= 8'd123));
        zero1_d   = (h_q == 8'd0) && (v_q == 8'd0);
    end

    // ------------------------------------------------------------------
    // Stage 2: framebuffer data and aligned outputs
    // ------------------------------------------------------------------
    logic [2:0] fb_q [0:NPIX-1];
    logic [2:0] rgb_q, rgb_d;
    logic       video_on_q, video_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       zero2_q, zero2_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        // fb_q is updated with non-blocking writes, so a same-edge write to
        // rd_addr_q is not visible here: the read returns the old entry.
        rgb_d         = vid1_q ? fb_q[rd_addr_q] : 3'd0;
        video_on_d    = vid1_q;
        hsync_d       = hs1_q;
        vsync_d       = vs1_q;
        zero2_d       = zero1_q;
        frame_start_d = zero1_q && !zero2_q;
    end

    // ------------------------------------------------------------------
    // Write path, drop counter, optional clear sweep
    // ------------------------------------------------------------------
    logic        wr_ok;
    logic        clr_we;
    logic [14:0] clr_addr;
    logic        fb_we;
    logic [14:0] fb_waddr;
    logic [2:0]  fb_wdata;
    logic [7:0]  drop_q, drop_d;

`ifdef VGA_PIXEL_SINK_CLEAR_EN
    // state   | meaning
    // S_CLEAR | writing 0 to one entry per clk, requests rejected
    // S_RUN   | normal operation
    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt_q == 15'd0) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q - 15'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= 15'(NPIX - 1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The sweep only counts once reset is released, so it is held low in reset.
    assign clearing = (state_q == S_CLEAR) && !reset;
    assign clr_addr = clr_cnt_q;
`else
    assign clearing = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = 15'd0;
`endif

    always_comb begin
        wr_ok    = writeEn && (x_in < 8'd160) && (y_in < 7'd120) && !clearing;
        fb_we    = 1'b0;
        fb_waddr = pix_addr(x_in, y_in);
        fb_wdata = color_in;
        if (!reset) begin
            if (clr_we) begin
                fb_we    = 1'b1;
                fb_waddr = clr_addr;
                fb_wdata = 3'd0;
            end else if (wr_ok) begin
                fb_we = 1'b1;
            end
        end
        drop_d = drop_q;
        if (writeEn && !wr_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fb_we) begin
            fb_q[fb_waddr] <= fb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= 8'd0;
            v_q           <= 8'd0;
            rd_addr_q     <= 15'd0;
            vid1_q        <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            zero1_q       <= 1'b0;
            rgb_q         <= 3'd0;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            zero2_q       <= 1'b0;
            frame_start_q <= 1'b0;
            drop_q        <= 8'd0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            rd_addr_q     <= rd_addr_d;
            vid1_q        <= vid1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            zero1_q       <= zero1_d;
            rgb_q         <= rgb_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            zero2_q       <= zero2_d;
            frame_start_q <= frame_start_d;
            drop_q        <= drop_d;
        end
    end

    assign rgb_out     = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
module tb_vga_pixel_sink;

    localparam int PD = 2;
    localparam int FRAME_CLKS = 200 * 131 * PD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x_in = 8'd0;
    logic [6:0] y_in = 7'd0;
    logic [2:0] color_in = 3'd0;
    logic       writeEn = 1'b0;
    logic [2:0] rgb_out;
    logic       hsync, vsync, video_on, frame_start, clearing;
    logic [7:0] drop_count;

    vga_pixel_sink #(.PIX_DIV(PD)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
        .color_in(color_in), .writeEn(writeEn), .rgb_out(rgb_out),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .frame_start(frame_start), .clearing(clearing),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fs_cyc = 0;
    int hs_lo = 0, vs_lo = 0, fs_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output state after each edge is counted once, at the following negedge.
    always @(negedge clk) begin
        if (hsync === 1'b0) hs_lo <= hs_lo + 1;
        if (vsync === 1'b0) vs_lo <= vs_lo + 1;
        if (frame_start === 1'b1) fs_n <= fs_n + 1;
    end

    typedef struct {
        int x; int y; int c; int drop;
    } wv_t;

    typedef struct {
        int h; int v; int s; int wr;
        int rgb; int vid; int hs; int vs;
    } sv_t;

    wv_t wv[12];
    sv_t sv[22];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        writeEn = 1'b0;
    endtask

    task automatic wr(input int x, input int y, input int c);
        x_in     = 8'(x);
        y_in     = 7'(y);
        color_in = 3'(c);
        writeEn  = 1'b1;
    endtask

    // Advance to the sample where the aligned output shows (h,v), clk s of the pixel.
    task automatic goto(input int h, input int v, input int s);
        int t;
        t = fs_cyc + (v * 200 + h) * PD + s;
        while (cyc < t) tick();
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < FRAME_CLKS + 1000) begin
            tick();
            n++;
        end
        chk("frame_start_seen", int'(frame_start === 1'b1), 1);
        fs_cyc = cyc;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rgb"}, int'(rgb_out), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_video_on"}, int'(video_on), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_drop"}, int'(drop_count), 0);
        chk({tag, "_clearing"}, int'(clearing), 0);
    endtask

    initial begin
        int fs_prev, hs0, vs0, fsn0, n;

`ifdef VGA_PIXEL_SINK_CLEAR_EN
        repeat (3) tick();
        chk_reset_outs("rst");
        reset = 1'b0;
        wr(5, 3, 7);
        n = 0;
        while (clearing === 1'b1 && n < 20000) begin
            n++;
            tick();
        end
        chk("clear1_len", n, 19200);
        chk("clear1_drop", int'(drop_count), 1);
        wr(5, 100, 7);
        tick();
        chk("preload_drop", int'(drop_count), 1);
        reset = 1'b1;
        tick();
        tick();
        chk("rst2_clearing", int'(clearing), 0);
        reset = 1'b0;
        n = 0;
        while (clearing === 1'b1 && n < 20000) begin
            if (frame_start === 1'b1) fs_cyc = cyc;
            if (n == 5) wr(5, 100, 7);
            n++;
            tick();
        end
        chk("clear2_len", n, 19200);
        chk("clear2_drop", int'(drop_count), 1);
        goto(5, 100, 0);
        chk("cleared_rgb", int'(rgb_out), 0);
        chk("cleared_vid", int'(video_on), 1);
`else
        wv[0]  = '{5, 3, 5, 0};
        wv[1]  = '{4, 3, 0, 0};
        wv[2]  = '{6, 3, 0, 0};
        wv[3]  = '{10, 10, 2, 0};
        wv[4]  = '{0, 1, 6, 0};
        wv[5]  = '{1, 1, 3, 0};
        wv[6]  = '{159, 119, 4, 0};
        wv[7]  = '{160, 0, 7, 1};
        wv[8]  = '{0, 120, 7, 2};
        wv[9]  = '{255, 127, 1, 3};
        wv[10] = '{159, 120, 5, 4};
        wv[11] = '{160, 119, 5, 5};

        //         h    v   s  wr rgb vid hs vs
        sv[0]  = '{0,   1,  0, 0, 6, 1, 1, 1};
        sv[1]  = '{1,   1,  1, 0, 3, 1, 1, 1};
        sv[2]  = '{4,   3,  1, 0, 0, 1, 1, 1};
        sv[3]  = '{5,   3,  0, 0, 5, 1, 1, 1};
        sv[4]  = '{5,   3,  1, 0, 5, 1, 1, 1};
        sv[5]  = '{6,   3,  0, 0, 0, 1, 1, 1};
        sv[6]  = '{160, 3,  0, 0, 0, 0, 1, 1};
        sv[7]  = '{167, 3,  1, 0, 0, 0, 1, 1};
        sv[8]  = '{168, 3,  0, 0, 0, 0, 0, 1};
        sv[9]  = '{183, 3,  1, 0, 0, 0, 0, 1};
        sv[10] = '{184, 3,  0, 0, 0, 0, 1, 1};
        sv[11] = '{10,  10, 0, 1, 2, 1, 1, 1};
        sv[12] = '{10,  10, 1, 0, 2, 1, 1, 1};
        sv[13] = '{159, 119, 0, 0, 4, 1, 1, 1};
        sv[14] = '{160, 119, 0, 0, 0, 0, 1, 1};
        sv[15] = '{0,   121, 0, 0, 0, 0, 1, 1};
        sv[16] = '{0,   122, 0, 0, 0, 0, 1, 0};
        sv[17] = '{199, 123, 1, 0, 0, 0, 1, 0};
        sv[18] = '{0,   124, 0, 0, 0, 0, 1, 1};
        sv[19] = '{175, 130, 0, 0, 0, 0, 0, 1};
        sv[20] = '{180, 130, 1, 0, 0, 0, 0, 1};
        sv[21] = '{199, 130, 1, 0, 0, 0, 1, 1};

        // Requests during reset: neither stored nor counted.
        repeat (2) begin
            wr(1, 1, 7);
            tick();
            wr(200, 0, 1);
            tick();
        end
        chk_reset_outs("rst");

        reset = 1'b0;
        tick();
        chk("e0_frame_start", int'(frame_start), 0);
        tick();
        chk("e1_frame_start", int'(frame_start), 1);
        chk("e1_video_on", int'(video_on), 1);
        fs_cyc = cyc;
        hs0 = hs_lo;
        vs0 = vs_lo;
        fsn0 = fs_n;

        for (int i = 0; i < 12; i++) begin
            wr(wv[i].x, wv[i].y, wv[i].c);
            tick();
            if (i == 0) chk("fs_one_clk", int'(frame_start), 0);
            chk($sformatf("wr%0d_drop", i), int'(drop_count), wv[i].drop);
        end

        for (int i = 0; i < 22; i++) begin
            goto(sv[i].h, sv[i].v, sv[i].s);
            chk($sformatf("scan%0d_rgb", i), int'(rgb_out), sv[i].rgb);
            chk($sformatf("scan%0d_vid", i), int'(video_on), sv[i].vid);
            chk($sformatf("scan%0d_hs", i), int'(hsync), sv[i].hs);
            chk($sformatf("scan%0d_vs", i), int'(vsync), sv[i].vs);
            chk($sformatf("scan%0d_fs", i), int'(frame_start), 0);
            if (sv[i].wr != 0) wr(10, 10, 6);
        end

        fs_prev = fs_cyc;
        wait_fs();
        chk("frame_period", fs_cyc - fs_prev, FRAME_CLKS);
        chk("hsync_low_clks", hs_lo - hs0, 131 * 16 * PD);
        chk("vsync_low_clks", vs_lo - vs0, 2 * 200 * PD);
        chk("fs_pulses", fs_n - fsn0, 1);

        goto(10, 10, 0);
        chk("collide_next_frame", int'(rgb_out), 6);

        goto(90, 60, 0);
        chk("pre_abort_vid", int'(video_on), 1);
        reset = 1'b1;
        wr(1, 1, 7);
        tick();
        wr(200, 0, 1);
        tick();
        chk_reset_outs("abort");
        reset = 1'b0;
        tick();
        chk("abort_e0_fs", int'(frame_start), 0);
        tick();
        chk("abort_e1_fs", int'(frame_start), 1);
        fs_cyc = cyc;

        goto(1, 1, 0);
        chk("rst_write_ignored", int'(rgb_out), 3);

        for (int i = 0; i < 300; i++) begin
            wr(200, 0, 1);
            tick();
            if (i == 0) chk("sat_1", int'(drop_count), 1);
            if (i == 254) chk("sat_255", int'(drop_count), 255);
        end
        chk("sat_hold", int'(drop_count), 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
